bcm_scan_scheduler: RTL and testbench

Sequences the LED matrix datapath: steps through row addresses and BCM bit planes, requests each plane's row data from the column shifter through a start/done handshake, and drives panel latch, row mux and output blanking with binary-weighted on-times. Sits between the frame-buffer/shifter path and the panel pins. It prefetches the next plane during the current plane's display time, so the panel goes dark only for the two-cycle blank/latch window whenever the shifter keeps up.

---
 rtl/led_matrix_pkg.sv | 33 +++
 rtl/bcm_on_timer.sv | 37 +++
 rtl/bcm_scan_scheduler.sv | 180 ++++++++++++++++++
 tb/tb_bcm_scan_scheduler.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/led_matrix_pkg.sv
// Shared types, default parameters and plane-order helpers for the LED matrix scan path.
package led_matrix_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FILL,
        BLANK,
        LATCH,
        DISPLAY,
        HOLD
    } scan_state_t;

    localparam int DEF_DATA_WIDTH        = 8;
    localparam int DEF_MUX_LENGTH        = 4;
    localparam int DEF_BASE_TICKS        = 4;
    localparam int DEF_WAIT_COUNT_LENGTH = 17;

    // Plane order is bit-major within a row and wraps (last row, last bit) -> (0, 0).
    function automatic int unsigned next_plane_bit(input int unsigned bit_idx,
                                                   input int unsigned planes);
        return (bit_idx + 1 >= planes) ? 0 : bit_idx + 1;
    endfunction

    function automatic int unsigned next_plane_row(input int unsigned row,
                                                   input int unsigned bit_idx,
                                                   input int unsigned rows,
                                                   input int unsigned planes);
        if (bit_idx + 1 < planes)
            return row;
        return (row + 1 >= rows) ? 0 : row + 1;
    endfunction

endpackage

// File: rtl/bcm_on_timer.sv
// Loadable display down-counter; flags the last display cycle and whether the LEDs
// should be lit in the following cycle.
module bcm_on_timer #(
    parameter int WIDTH = 17
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic [WIDTH-1:0] on_val,
    output logic             expired,
    output logic             on_window
);

    logic [WIDTH-1:0] count;
    logic [WIDTH-1:0] on_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count    <= '0;
            on_count <= '0;
        end else if (load) begin
            count    <= load_val;
            on_count <= on_val;
        end else begin
            if (count != '0)
                count <= count - WIDTH'(1);
            if (on_count != '0)
                on_count <= on_count - WIDTH'(1);
        end
    end

    // Both flags look one cycle ahead so the scheduler can register oe_n.
    assign expired   = (count < WIDTH'(2));
    assign on_window = load ? (on_val != '0) : (on_count > WIDTH'(1));

endmodule

// File: rtl/bcm_scan_scheduler.sv
// Row/bit-plane scan sequencer with shifter prefetch and binary-weighted on-times.
// Optional global dimming input enabled by defining BCM_BRIGHTNESS_EN.
//
// state   | meaning
// IDLE    | panel dark, waiting for enable
// FILL    | first plane requested, waiting for shift_done
// BLANK   | panel dark, row mux moves to the plane just shifted
// LATCH   | latch pulse, timer load, prefetch of the next plane
// DISPLAY | plane on-time counting down
// HOLD    | display done but prefetch still outstanding
module bcm_scan_scheduler
    import led_matrix_pkg::*;
#(
    parameter int DATA_WIDTH        = DEF_DATA_WIDTH,
    parameter int MUX_LENGTH        = DEF_MUX_LENGTH,
    parameter int BASE_TICKS        = DEF_BASE_TICKS,
    parameter int WAIT_COUNT_LENGTH = DEF_WAIT_COUNT_LENGTH,
    parameter int BW                = $clog2(DATA_WIDTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    output logic                  shift_start,
    output logic [MUX_LENGTH-1:0] shift_row,
    output logic [BW-1:0]         shift_bit,
    input  logic                  shift_done,
    output logic [MUX_LENGTH-1:0] mux_val,
    output logic                  latch,
    output logic                  oe_n,
    output logic                  frame_done
`ifdef BCM_BRIGHTNESS_EN
    ,
    input  logic [7:0]            brightness
`endif
);

    localparam int ROWS = 2 ** MUX_LENGTH;

    if (BASE_TICKS < 1 || DATA_WIDTH < 2 || MUX_LENGTH < 1 ||
        (longint'(BASE_TICKS) << (DATA_WIDTH - 1)) >= (longint'(1) << WAIT_COUNT_LENGTH)) begin : g_bad_params
        $error("bcm_scan_scheduler: illegal parameter combination");
    end

    scan_state_t                  state;
    logic                         outstanding;
    logic                         plane_ready;
    logic [BW-1:0]                disp_bit;
    logic                         disp_last;
    logic                         done_ok;
    logic                         go_blank;
    logic                         go_hold;
    logic                         go_idle;
    logic                         expired;
    logic                         on_window;
    logic [WAIT_COUNT_LENGTH-1:0] load_val;
    logic [WAIT_COUNT_LENGTH-1:0] on_val;

    assign load_val = WAIT_COUNT_LENGTH'(BASE_TICKS) << disp_bit;

`ifdef BCM_BRIGHTNESS_EN
    logic [WAIT_COUNT_LENGTH+8:0] on_prod;
    assign on_prod = (WAIT_COUNT_LENGTH + 9)'(load_val) *
                     (WAIT_COUNT_LENGTH + 9)'({1'b0, brightness} + 9'd1);
    assign on_val  = WAIT_COUNT_LENGTH'(on_prod >> 8);
`else
    assign on_val  = load_val;
`endif

    bcm_on_timer #(
        .WIDTH(WAIT_COUNT_LENGTH)
    ) u_on_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (state == LATCH),
        .load_val (load_val),
        .on_val   (on_val),
        .expired  (expired),
        .on_window(on_window)
    );

    // A stray shift_done with nothing requested is ignored; plane_ready only
    // lets DISPLAY move on when a prefetch was actually issued and delivered.
    always_comb begin
        done_ok  = shift_done && outstanding;
        go_blank = 1'b0;
        go_hold  = 1'b0;
        go_idle  = 1'b0;
        case (state)
            FILL:    go_blank = done_ok;
            DISPLAY: begin
                if (expired) begin
                    if (outstanding && !shift_done)
                        go_hold = 1'b1;
                    else if (enable && (plane_ready || done_ok))
                        go_blank = 1'b1;
                    else
                        go_idle = 1'b1;
                end
            end
            HOLD: begin
                go_blank = done_ok && enable;
                go_idle  = done_ok && !enable;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            shift_start <= 1'b0;
            shift_row   <= '0;
            shift_bit   <= '0;
            mux_val     <= '0;
            latch       <= 1'b0;
            oe_n        <= 1'b1;
            frame_done  <= 1'b0;
            outstanding <= 1'b0;
            plane_ready <= 1'b0;
            disp_bit    <= '0;
            disp_last   <= 1'b0;
        end else begin
            shift_start <= 1'b0;
            latch       <= 1'b0;
            frame_done  <= 1'b0;
            if (done_ok) begin
                outstanding <= 1'b0;
                plane_ready <= 1'b1;
            end
            if (go_blank) begin
                state       <= BLANK;
                oe_n        <= 1'b1;
                mux_val     <= shift_row;
                disp_bit    <= shift_bit;
                disp_last   <= (&shift_row) && (shift_bit == BW'(DATA_WIDTH - 1));
                plane_ready <= 1'b0;
            end else if (go_hold) begin
                state <= HOLD;
                oe_n  <= 1'b1;
            end else if (go_idle) begin
                state       <= IDLE;
                oe_n        <= 1'b1;
                plane_ready <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        oe_n <= 1'b1;
                        if (enable) begin
                            state       <= FILL;
                            shift_start <= 1'b1;
                            shift_row   <= '0;
                            shift_bit   <= '0;
                            outstanding <= 1'b1;
                            plane_ready <= 1'b0;
                        end
                    end
                    BLANK: begin
                        state      <= LATCH;
                        latch      <= 1'b1;
                        frame_done <= disp_last;
                        shift_row  <= MUX_LENGTH'(next_plane_row(32'(shift_row), 32'(shift_bit),
                                                                 ROWS, DATA_WIDTH));
                        shift_bit  <= BW'(next_plane_bit(32'(shift_bit), DATA_WIDTH));
                        if (enable) begin
                            shift_start <= 1'b1;
                            outstanding <= 1'b1;
                        end
                    end
                    LATCH: begin
                        state <= DISPLAY;
                        oe_n  <= !on_window;
                    end
                    DISPLAY: oe_n <= !on_window;
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_bcm_scan_scheduler.sv
// Directed bench for bcm_scan_scheduler: plane timing, frame period, HOLD, enable drop,
// async reset, and (with BCM_BRIGHTNESS_EN) dimmed on-times.
module tb_bcm_scan_scheduler;

    logic       clk;
    logic       rst;
    logic       enable;
    logic       shift_start;
    logic [3:0] shift_row;
    logic [2:0] shift_bit;
    logic       shift_done;
    logic [3:0] mux_val;
    logic       latch;
    logic       oe_n;
    logic       frame_done;
    logic [7:0] brightness;

    int n_cmp = 0;
    int n_err = 0;
    int shift_delay = 3;
    int sh_cnt;

    bcm_scan_scheduler dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .shift_start(shift_start),
        .shift_row  (shift_row),
        .shift_bit  (shift_bit),
        .shift_done (shift_done),
        .mux_val    (mux_val),
        .latch      (latch),
        .oe_n       (oe_n),
        .frame_done (frame_done)
`ifdef BCM_BRIGHTNESS_EN
        ,
        .brightness (brightness)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Shifter model: shift_done pulses shift_delay cycles after the shift_start cycle.
    initial begin
        shift_done = 1'b0;
        sh_cnt     = 0;
        forever begin
            @(negedge clk);
            shift_done = 1'b0;
            if (rst) begin
                sh_cnt = 0;
            end else begin
                if (sh_cnt > 0) begin
                    sh_cnt--;
                    if (sh_cnt == 0)
                        shift_done = 1'b1;
                end
                if (shift_start)
                    sh_cnt = shift_delay;
            end
        end
    end

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs until the next latch pulse; reports cycles, oe_n-low cycles and extra starts.
    task automatic wait_latch(input int budget, output int cycles, output int low, output int starts);
        cycles = 0;
        low    = 0;
        starts = 0;
        do begin
            tick();
            cycles++;
            if (!oe_n) low++;
            if (shift_start && !latch) starts++;
        end while (!latch && cycles < budget);
        if (!latch)
            check_val("latch_wait", 32'(latch), 1);
    endtask

    task automatic wait_fd(input int budget, output int cycles, output int changes, output int bad);
        logic [3:0] prev;
        prev    = mux_val;
        cycles  = 0;
        changes = 0;
        bad     = 0;
        do begin
            tick();
            cycles++;
            if (mux_val != prev) begin
                changes++;
                if (mux_val != 4'(prev + 4'd1)) bad++;
                prev = mux_val;
            end
        end while (!frame_done && cycles < budget);
        if (!frame_done)
            check_val("frame_done_wait", 32'(frame_done), 1);
    endtask

    task automatic run_cycles(input int n, output int low, output int starts, output int latches);
        low     = 0;
        starts  = 0;
        latches = 0;
        for (int i = 0; i < n; i++) begin
            tick();
            if (!oe_n) low++;
            if (shift_start) starts++;
            if (latch) latches++;
        end
    endtask

    task automatic check_reset_outputs(input string pfx);
        check_val({pfx, "_shift_start"}, 32'(shift_start), 0);
        check_val({pfx, "_shift_row"},   32'(shift_row),   0);
        check_val({pfx, "_shift_bit"},   32'(shift_bit),   0);
        check_val({pfx, "_mux_val"},     32'(mux_val),     0);
        check_val({pfx, "_latch"},       32'(latch),       0);
        check_val({pfx, "_oe_n"},        32'(oe_n),        1);
        check_val({pfx, "_frame_done"},  32'(frame_done),  0);
    endtask

    initial begin
        int cyc, low, st, lat, chg, bad, low2;
        rst        = 1'b1;
        enable     = 1'b0;
        brightness = 8'd255;

        repeat (3) tick();
        check_reset_outputs("rst");
        rst = 1'b0;
        repeat (2) tick();

        // First plane: start on the enable edge, latch 5 edges later with a 3-cycle shifter.
        enable = 1'b1;
        tick();
        check_val("start_on_enable", 32'(shift_start), 1);
        wait_latch(100, cyc, low, st);
        check_val("first_latch_edges", cyc, 5);
        for (int b = 0; b < 8; b++) begin
            wait_latch(2000, cyc, low, st);
            check_val($sformatf("oe_low_p%0d", b), low, 4 << b);
            check_val($sformatf("period_p%0d", b), cyc, 2 + (4 << b));
        end
        check_val("mux_row1", 32'(mux_val), 1);

        // Full frames with an immediate shifter.
        shift_delay = 1;
        wait_fd(20000, cyc, chg, bad);
        wait_fd(20000, cyc, chg, bad);
        check_val("frame_period", cyc, 16576);
        check_val("mux_steps", chg, 16);
        check_val("mux_bad_steps", bad, 0);
        check_val("mux_at_frame_done", 32'(mux_val), 15);

        // Slow shifter on plane 0 forces HOLD.
        shift_delay = 20;
        wait_latch(1000, cyc, low, st);
        check_val("period_p15_7", cyc, 514);
        wait_latch(1000, cyc, low, st);
        check_val("hold_oe_low", low, 4);
        check_val("hold_period", cyc, 22);
        check_val("prefetch_row", 32'(shift_row), 0);
        check_val("prefetch_bit", 32'(shift_bit), 2);
        shift_delay = 1;
        wait_latch(1000, cyc, low, st);
        check_val("p1_oe_low", low, 8);
        shift_delay = 200;
        wait_latch(1000, cyc, low, st);
        check_val("hold_p2_period", cyc, 202);

        // Drop enable mid-DISPLAY of plane 3 with a shift outstanding.
        run_cycles(5, low, st, lat);
        enable = 1'b0;
        run_cycles(400, low2, st, lat);
        check_val("drop_oe_low", low + low2, 32);
        check_val("drop_no_start", st, 0);
        check_val("drop_no_latch", lat, 0);
        check_val("drop_oe_n_idle", 32'(oe_n), 1);

        shift_delay = 3;
        enable = 1'b1;
        tick();
        check_val("restart_start", 32'(shift_start), 1);
        check_val("restart_row", 32'(shift_row), 0);
        check_val("restart_bit", 32'(shift_bit), 0);

        // Asynchronous reset during DISPLAY.
        wait_latch(100, cyc, low, st);
        check_val("restart_latch_edges", cyc, 5);
        tick();
        tick();
        check_val("display_oe_n", 32'(oe_n), 0);
        #2;
        rst = 1'b1;
        #1;
        check_reset_outputs("async_rst");
        enable = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        tick();

`ifdef BCM_BRIGHTNESS_EN
        shift_delay = 1;
        brightness  = 8'd127;
        enable      = 1'b1;
        for (int i = 0; i < 3; i++) wait_latch(1000, cyc, low, st);
        wait_latch(1000, cyc, low, st);
        check_val("dim127_p2_low", low, 8);
        check_val("dim127_p2_period", cyc, 18);
        brightness = 8'd255;
        for (int i = 0; i < 7; i++) wait_latch(1000, cyc, low, st);
        wait_latch(1000, cyc, low, st);
        check_val("dim255_p2_low", low, 16);
        check_val("dim255_p2_period", cyc, 18);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
